pixel_plot_sink: RTL and testbench
==================================

// Module: pixel_plot_sink
// PURPOSE
//  Consumer end of the sprite plot stream (plot / x_pix / y_pix / color).
//  Clips off-screen pixels, discards transparent pixels, linearises (x,y) to a
//  framebuffer address and buffers writes in a small FIFO ahead of a
//  ready-throttled framebuffer write port. Sits between the sprite drawers and
//  the VGA framebuffer memory. The plot stream has no backpressure, so overflow
//  is reported, never stalled.
// PARAMETERS
//  SCREEN_W    160     visible width in pixels; valid x is 0..SCREEN_W-1
//  SCREEN_H    120     visible height in pixels; valid y is 0..SCREEN_H-1
//  ADDR_W      15      framebuffer address width; must be >= clog2(SCREEN_W*SCREEN_H)
//  FIFO_DEPTH  4       write FIFO entries; must be a power of 2 and >= 2
//  TRANSP_EN   1       1 = drop pixels whose colour equals TRANSPARENT
//  TRANSPARENT 3'b000  colour code treated as transparent
// PORTS
//  clk           in   1       system clock; all logic on the rising edge
//  reset_n       in   1       synchronous reset, active-low
//  plot          in   1       pixel valid for this cycle
//  x_pix         in   10      pixel x coordinate
//  y_pix         in   10      pixel y coordinate
//  color         in   3       pixel colour
//  clear_status  in   1       clears overflow and drop_count
//  fb_ready      in   1       framebuffer accepts a write this cycle
//  fb_we         out  1       framebuffer write request (= FIFO not empty)
//  fb_addr       out  ADDR_W  write address, y*SCREEN_W + x
//  fb_color      out  3       write data
//  full          out  1       FIFO holds FIFO_DEPTH entries
//  idle          out  1       stage-1 register empty AND FIFO empty
//  overflow      out  1       sticky: a valid pixel was lost because the FIFO was full
//  drop_count    out  8       saturating count of clipped plus transparent pixels
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge):
//   - Stage-1 valid cleared; FIFO emptied.
//   - fb_we=0, full=0, overflow=0, drop_count=0, idle=1.
//   - fb_addr=0 and fb_color=0.
//   - Applies mid-operation too; in-flight pixels are discarded.
//  Stage 1 (registered at every edge):
//   - Captures plot, x_pix, y_pix, color.
//   - s1_keep = plot & x_pix<SCREEN_W & y_pix<SCREEN_H & !(TRANSP_EN & color==TRANSPARENT).
//   - When plot=1 and s1_keep=0, drop_count increments, saturating at 255.
//  Stage 2 (push):
//   - Pushes {addr, colour} from stage 1 when the stage-1 pixel was kept.
//   - addr = y*SCREEN_W + x, computed at ADDR_W bits. No overflow is possible
//     because clipping has already happened.
//   - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same
//     cycle (full + pop + push gives count unchanged).
//   - Otherwise the pixel is lost and overflow is set to 1.
//  Output:
//   - The FIFO is show-ahead: fb_we, fb_addr and fb_color reflect the head.
//   - Pop occurs when fb_we & fb_ready.
//   - Order is strictly FIFO.
//   - While fb_we=0, fb_addr and fb_color hold their last values.
//  Latency:
//   - plot at edge N, empty FIFO: fb_we=1 with that pixel's data in the cycle
//     after edge N+1.
//   - Throughput is 1 pixel/clk while fb_ready=1.
//  clear_status:
//   - Zeroes overflow and drop_count at the edge.
//   - An event in the same cycle as clear_status takes priority, giving
//     overflow=1 or drop_count=1.
//  full = (count==FIFO_DEPTH). Count wraps are handled by the pointer MSBs.
// TESTING
//  - plot x=5 y=2 color=3'b101, fb_ready=1 -> fb_we=1 for 1 cycle after 2
//    edges, fb_addr=325, fb_color=5.
//  - plot (160,0) c=1, then (0,120) c=1, then (3,3) c=0 -> no fb_we,
//    drop_count=3, overflow=0.
//  - fb_ready=0; 5 back-to-back valid pixels a..e (DEPTH=4) -> full=1,
//    e lost, overflow=1. Then fb_ready=1 -> 4 writes a,b,c,d in order, full=0.
//  - FIFO full, fb_ready=1, new valid pixel pushed -> accepted, count stays 4,
//    overflow stays 0.
//  - 300 transparent plots -> drop_count=255. Then clear_status -> 0.
//  - reset_n=0 with 3 entries queued -> next cycle fb_we=0, idle=1,
//    drop_count=0, overflow=0.

Source files
------------

// File: rtl/pixel_plot_sink_if.sv
// ---------------------------------------------------------------------------
// pixel_plot_sink_if
// Bundles the two streaming sides of the pixel sink:
//   - plot stream (sprite drawers -> sink): plot, x_pix, y_pix, color
//   - framebuffer write port (sink -> memory): fb_we, fb_addr, fb_color,
//     throttled by fb_ready
// Modports:
//   master : environment side (drives the plot stream and fb_ready)
//   slave  : the sink itself (consumes the plot stream, drives the write port)
// ---------------------------------------------------------------------------
interface pixel_plot_sink_if #(
    parameter int ADDR_W = 15
);
    logic              plot;
    logic [9:0]        x_pix;
    logic [9:0]        y_pix;
    logic [2:0]        color;
    logic              fb_ready;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [2:0]        fb_color;

    modport master (
        output plot, x_pix, y_pix, color, fb_ready,
        input  fb_we, fb_addr, fb_color
    );

    modport slave (
        input  plot, x_pix, y_pix, color, fb_ready,
        output fb_we, fb_addr, fb_color
    );
endinterface

// File: rtl/pixel_plot_sink.sv
// ---------------------------------------------------------------------------
// pixel_plot_sink
// Consumer end of the sprite plot stream. Each plotted pixel is registered,
// clipped against the visible screen and optionally dropped when transparent.
// Surviving pixels are linearised to y*SCREEN_W + x and queued in a small
// show-ahead FIFO that feeds a ready-throttled framebuffer write port. The
// plot stream cannot be stalled, so a pixel arriving at a full FIFO is lost
// and flagged in the sticky overflow bit.
// Ports:
//   clk          : system clock, rising edge
//   reset_n      : synchronous active-low reset
//   bus (slave)  : plot/x_pix/y_pix/color in, fb_ready in,
//                  fb_we/fb_addr/fb_color out (FIFO head)
//   clear_status : zeroes overflow and drop_count (new events win)
//   full         : FIFO holds FIFO_DEPTH entries
//   idle         : no pixel in stage 1 and FIFO empty
//   overflow     : sticky, a kept pixel was lost to a full FIFO
//   drop_count   : saturating count of clipped plus transparent pixels
// ---------------------------------------------------------------------------
module pixel_plot_sink #(
    parameter int       SCREEN_W    = 160,
    parameter int       SCREEN_H    = 120,
    parameter int       ADDR_W      = 15,
    parameter int       FIFO_DEPTH  = 4,
    parameter bit       TRANSP_EN   = 1'b1,
    parameter bit [2:0] TRANSPARENT = 3'b000
) (
    input  logic                clk,
    input  logic                reset_n,
    pixel_plot_sink_if.slave    bus,
    input  logic                clear_status,
    output logic                full,
    output logic                idle,
    output logic                overflow,
    output logic [7:0]          drop_count
);

    localparam int          PTR_W = $clog2(FIFO_DEPTH);
    localparam int          ENT_W = ADDR_W + 3;
    localparam logic [10:0] X_LIM = 11'(SCREEN_W);
    localparam logic [10:0] Y_LIM = 11'(SCREEN_H);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Clipping has already bounded x and y, so this cannot overflow ADDR_W.
    function automatic logic [ADDR_W-1:0] lin_addr(input logic [9:0] x,
                                                   input logic [9:0] y);
        return ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);
    endfunction

    // ---------------- stage 1: capture and classify ----------------
    logic       in_keep;
    logic       in_drop;
    logic       s1_vld_q;
    logic [9:0] s1_x_q;
    logic [9:0] s1_y_q;
    logic [2:0] s1_color_q;

    always_comb begin
        in_keep = bus.plot
                  && ({1'b0, bus.x_pix} < X_LIM)
                  && ({1'b0, bus.y_pix} < Y_LIM)
                  && !(TRANSP_EN && (bus.color == TRANSPARENT));
        in_drop = bus.plot && !in_keep;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= in_keep;
        end
    end

    always_ff @(posedge clk) begin
        s1_x_q     <= bus.x_pix;
        s1_y_q     <= bus.y_pix;
        s1_color_q <= bus.color;
    end

    // ---------------- stage 2: FIFO push / pop ----------------
    logic [PTR_W:0]      wr_ptr_q;
    logic [PTR_W:0]      rd_ptr_q;
    logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]   hold_addr_q;
    logic [2:0]          hold_color_q;
    logic                ovf_q;
    logic [7:0]          drop_q;

    logic                empty;
    logic                pop;
    logic                push_ok;
    logic                lost;
    logic [ENT_W-1:0]    head;
    logic [ENT_W-1:0]    s1_entry;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        // Pointers carry one extra MSB so equal low bits with differing MSBs means full.
        full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W])
                   && (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        pop      = !empty && bus.fb_ready;
        // A pop in the same cycle frees the slot the push lands in.
        push_ok  = s1_vld_q && (!full || pop);
        lost     = s1_vld_q && full && !pop;
        head     = mem_q[rd_ptr_q[PTR_W-1:0]];
        s1_entry = {lin_addr(s1_x_q, s1_y_q), s1_color_q};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ovf_q        <= 1'b0;
            drop_q       <= 8'd0;
            hold_addr_q  <= '0;
            hold_color_q <= 3'd0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;

            // Events in the clear cycle win over the clear.
            if (lost) begin
                ovf_q <= 1'b1;
            end else if (clear_status) begin
                ovf_q <= 1'b0;
            end

            if (in_drop) begin
                drop_q <= clear_status ? 8'd1 : sat_inc(drop_q);
            end else if (clear_status) begin
                drop_q <= 8'd0;
            end

            // Remembers the last presented head so the port holds while empty.
            hold_addr_q  <= bus.fb_addr;
            hold_color_q <= bus.fb_color;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= s1_entry;
        end
    end

    // ---------------- output: show-ahead head ----------------
    assign bus.fb_we    = !empty;
    assign bus.fb_addr  = empty ? hold_addr_q  : head[ENT_W-1:3];
    assign bus.fb_color = empty ? hold_color_q : head[2:0];

    assign idle       = !s1_vld_q && empty;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_pixel_plot_sink.sv
module tb_pixel_plot_sink;
    localparam int ADDR_W = 15;
    localparam int DEPTH  = 4;
    localparam int SW     = 160;
    localparam int SH     = 120;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear_status;
    logic       full;
    logic       idle;
    logic       overflow;
    logic [7:0] drop_count;

    pixel_plot_sink_if #(.ADDR_W(ADDR_W)) bus ();

    pixel_plot_sink #(
        .SCREEN_W(SW), .SCREEN_H(SH), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH),
        .TRANSP_EN(1'b1), .TRANSPARENT(3'b000)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave),
        .clear_status(clear_status),
        .full(full),
        .idle(idle),
        .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int q_addr[$];
    int q_col[$];
    bit pend;
    int pend_addr, pend_col;
    bit m_ovf;
    int m_drop;
    int last_addr, last_col;
    bit m_pop, m_lost, m_kept, m_dropped;
    bit check_en = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            q_addr.delete();
            q_col.delete();
            pend = 0; m_ovf = 0; m_drop = 0; last_addr = 0; last_col = 0;
        end else begin
            if (q_addr.size() > 0) begin
                last_addr = q_addr[0];
                last_col  = q_col[0];
            end
            m_pop = (q_addr.size() > 0) && bus.fb_ready;
            if (m_pop) begin
                void'(q_addr.pop_front());
                void'(q_col.pop_front());
            end
            m_lost = 0;
            if (pend) begin
                if (q_addr.size() < DEPTH) begin
                    q_addr.push_back(pend_addr);
                    q_col.push_back(pend_col);
                end else begin
                    m_lost = 1;
                end
            end
            if (m_lost) m_ovf = 1;
            else if (clear_status) m_ovf = 0;

            m_kept    = bus.plot && (int'(bus.x_pix) < SW) && (int'(bus.y_pix) < SH)
                        && (bus.color != 3'd0);
            m_dropped = bus.plot && !m_kept;
            if (m_dropped) m_drop = clear_status ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
            else if (clear_status) m_drop = 0;

            pend      = m_kept;
            pend_addr = int'(bus.y_pix) * SW + int'(bus.x_pix);
            pend_col  = int'(bus.color);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("fb_we", bus.fb_we, (q_addr.size() > 0));
            if (q_addr.size() > 0) begin
                chk("fb_addr", bus.fb_addr, q_addr[0]);
                chk("fb_color", bus.fb_color, q_col[0]);
            end else begin
                chk("fb_addr_hold", bus.fb_addr, last_addr);
                chk("fb_color_hold", bus.fb_color, last_col);
            end
            chk("full", full, (q_addr.size() == DEPTH));
            chk("idle", idle, (!pend && q_addr.size() == 0));
            chk("overflow", overflow, m_ovf);
            chk("drop_count", drop_count, m_drop);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pix(input int x, input int y, input int c);
        bus.plot  = 1'b1;
        bus.x_pix = 10'(x);
        bus.y_pix = 10'(y);
        bus.color = 3'(c);
        step(1);
        bus.plot  = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        clear_status = 1'b0;
        bus.plot     = 1'b0;
        bus.x_pix    = '0;
        bus.y_pix    = '0;
        bus.color    = '0;
        bus.fb_ready = 1'b1;
        step(1);
        check_en = 1'b1;
        chk("reset_fb_we", bus.fb_we, 0);
        chk("reset_idle", idle, 1);
        chk("reset_fb_addr", bus.fb_addr, 0);
        step(1);
        reset_n = 1'b1;
        step(1);

        // single pixel: visible two edges after plot, one write
        pix(5, 2, 5);
        chk("t1_not_yet", bus.fb_we, 0);
        step(1);
        chk("t1_we", bus.fb_we, 1);
        chk("t1_addr", bus.fb_addr, 325);
        chk("t1_color", bus.fb_color, 5);
        step(1);
        chk("t1_one_cycle", bus.fb_we, 0);
        chk("t1_hold_addr", bus.fb_addr, 325);

        // clipping and transparency
        pix(160, 0, 1);
        pix(0, 120, 1);
        pix(3, 3, 0);
        step(3);
        chk("t2_drop", drop_count, 3);
        chk("t2_ovf", overflow, 0);
        chk("t2_we", bus.fb_we, 0);

        // overflow with fb_ready low
        bus.fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) pix(i, 0, i + 1);
        step(2);
        chk("t3_full", full, 1);
        chk("t3_ovf", overflow, 1);
        bus.fb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_order_addr", bus.fb_addr, i);
            chk("t3_order_col", bus.fb_color, i + 1);
            step(1);
        end
        chk("t3_drained", bus.fb_we, 0);
        chk("t3_not_full", full, 0);

        clear_status = 1'b1;
        step(1);
        clear_status = 1'b0;
        chk("clr_ovf", overflow, 0);
        chk("clr_drop", drop_count, 0);

        // full + pop + push keeps count at DEPTH
        bus.fb_ready = 1'b0;
        for (int i = 0; i < 4; i++) pix(10 + i, 1, 6);
        step(1);
        chk("t4_full", full, 1);
        pix(20, 1, 7);
        bus.fb_ready = 1'b1;
        step(1);
        chk("t4_still_full", full, 1);
        chk("t4_no_ovf", overflow, 0);
        chk("t4_head", bus.fb_addr, 171);
        step(5);
        chk("t4_drained", bus.fb_we, 0);
        chk("t4_last", bus.fb_addr, 180);

        // drop_count saturation and clear
        bus.plot  = 1'b1;
        bus.x_pix = 10'd1;
        bus.y_pix = 10'd1;
        bus.color = 3'd0;
        step(300);
        bus.plot = 1'b0;
        step(1);
        chk("t5_sat", drop_count, 255);
        clear_status = 1'b1;
        step(1);
        clear_status = 1'b0;
        chk("t5_clear", drop_count, 0);
        clear_status = 1'b1;
        pix(1, 1, 0);
        clear_status = 1'b0;
        chk("t5_clear_vs_event", drop_count, 1);

        // reset mid-operation
        bus.fb_ready = 1'b0;
        pix(7, 7, 2);
        pix(8, 7, 2);
        pix(9, 7, 2);
        step(1);
        chk("t6_queued", bus.fb_we, 1);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        chk("t6_we", bus.fb_we, 0);
        chk("t6_idle", idle, 1);
        chk("t6_drop", drop_count, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_addr", bus.fb_addr, 0);
        bus.fb_ready = 1'b1;
        step(3);

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
